instr_fetch_hs_unit: RTL and testbench

- Parametrised successor to the multi-cycle fetch unit: owns PC, IR and EPC, and drives the PC next-state mux.
- Replaces the fixed single-cycle RAM read with a req/ready memory handshake. Adds a fetch FSM, a bus timeout, misaligned-PC detection, and exception vectoring that aborts and drains any in-flight fetch.
- Sits between the main control FSM and the instruction memory port.

---
 rtl/instr_fetch_hs_unit.sv | 167 ++++++++++++++++
 tb/tb_instr_fetch_hs_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_hs_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_hs_unit
// Description : Instruction fetch unit owning PC/IR/EPC, with a req/ready
//               memory handshake, bus timeout, misaligned-PC trap and
//               exception vectoring that drains any in-flight fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_hs_unit #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       INSTR_WIDTH   = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = '0,
    parameter logic [ADDRESS_WIDTH-1:0] EXC_VECTOR    = ADDRESS_WIDTH'(32'h0000_0180),
    parameter int                       TIMEOUT       = 15
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     FETCH_REQ,
    input  logic                     PC_LOAD,
    input  logic [2:0]               PC_SEL,
    input  logic                     EXC,
    input  logic [ADDRESS_WIDTH-1:0] ALU_OUT,
    input  logic [ADDRESS_WIDTH-1:0] ALU_REG_OUT,
    input  logic [ADDRESS_WIDTH-1:0] Reg1_Out,
    input  logic                     MEM_READY,
    input  logic [INSTR_WIDTH-1:0]   MEM_RDATA,
    output logic                     MEM_REQ,
    output logic [ADDRESS_WIDTH-1:0] MEM_ADDR,
    output logic [INSTR_WIDTH-1:0]   Instr,
    output logic                     IR_VALID,
    output logic [ADDRESS_WIDTH-1:0] PC_OUT,
    output logic [ADDRESS_WIDTH-1:0] EPC_OUT,
    output logic                     FETCH_BUSY,
    output logic                     FETCH_ERR
);

    localparam int c_CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CW-1:0] c_to_last = (TIMEOUT > 0) ? c_CW'(TIMEOUT - 1) : '0;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_req   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_err   = 2'd3;

    logic [1:0]               r_state;
    logic [c_CW-1:0]          r_count;
    logic [ADDRESS_WIDTH-1:0] r_pc;
    logic [ADDRESS_WIDTH-1:0] r_epc;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [INSTR_WIDTH-1:0]   r_instr;
    logic                     r_ir_valid;
    logic                     r_mem_req;
    logic                     r_fetch_err;

    logic [ADDRESS_WIDTH-1:0] w_jump_target;
    logic [ADDRESS_WIDTH-1:0] w_pc_next;
    logic                     w_timeout;

    // Jump target keeps the PC's upper region bits above bit 27.
    generate
        if (ADDRESS_WIDTH > 28) begin : g_jump_region
            assign w_jump_target = {r_pc[ADDRESS_WIDTH-1:28], r_instr[25:0], 2'b00};
        end else begin : g_jump_flat
            assign w_jump_target = {r_instr[25:0], 2'b00};
        end
    endgenerate

    always_comb begin
        w_pc_next = r_pc;
        case (PC_SEL)
            3'd0:    w_pc_next = ALU_OUT;
            3'd1:    w_pc_next = ALU_REG_OUT;
            3'd2:    w_pc_next = w_jump_target;
            3'd3:    w_pc_next = Reg1_Out;
            3'd4:    w_pc_next = RESET_VECTOR;
            3'd5:    w_pc_next = EXC_VECTOR;
            default: w_pc_next = r_pc;
        endcase
    end

    assign w_timeout = (TIMEOUT != 0) && (r_count == c_to_last);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= c_st_idle;
            r_count     <= '0;
            r_pc        <= RESET_VECTOR;
            r_epc       <= '0;
            r_mem_addr  <= '0;
            r_instr     <= '0;
            r_ir_valid  <= 1'b0;
            r_mem_req   <= 1'b0;
            r_fetch_err <= 1'b0;
        end else begin
            r_fetch_err <= 1'b0;

            if (EXC) begin
                r_epc      <= r_pc;
                r_pc       <= EXC_VECTOR;
                r_ir_valid <= 1'b0;
            end else if (PC_LOAD) begin
                r_pc <= w_pc_next;
            end

            case (r_state)
                c_st_idle: begin
                    if (!EXC && FETCH_REQ) begin
                        r_ir_valid <= 1'b0;
                        if (r_pc[1:0] != 2'b00) begin
                            r_state     <= c_st_err;
                            r_fetch_err <= 1'b1;
                        end else begin
                            r_state    <= c_st_req;
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_pc;
                            r_count    <= '0;
                        end
                    end
                end
                c_st_req: begin
                    // A ready coinciding with EXC completes the bus cycle, so
                    // there is nothing left to drain; the data is dropped.
                    if (MEM_READY) begin
                        r_state   <= c_st_idle;
                        r_mem_req <= 1'b0;
                        if (!EXC) begin
                            r_instr    <= MEM_RDATA;
                            r_ir_valid <= 1'b1;
                        end
                    end else if (EXC) begin
                        r_state <= c_st_drain;
                        r_count <= '0;
                    end else if (w_timeout) begin
                        r_state     <= c_st_err;
                        r_mem_req   <= 1'b0;
                        r_fetch_err <= 1'b1;
                        r_ir_valid  <= 1'b0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                c_st_drain: begin
                    if (MEM_READY || w_timeout) begin
                        r_state   <= c_st_idle;
                        r_mem_req <= 1'b0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign MEM_REQ    = r_mem_req;
    assign MEM_ADDR   = r_mem_addr;
    assign Instr      = r_instr;
    assign IR_VALID   = r_ir_valid;
    assign PC_OUT     = r_pc;
    assign EPC_OUT    = r_epc;
    assign FETCH_BUSY = (r_state != c_st_idle);
    assign FETCH_ERR  = r_fetch_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_hs_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_hs_unit
// Description : Directed bench for instr_fetch_hs_unit with an instruction
//               scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_hs_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FETCH_REQ = 1'b0;
    logic        PC_LOAD = 1'b0;
    logic [2:0]  PC_SEL = 3'd0;
    logic        EXC = 1'b0;
    logic [31:0] ALU_OUT = '0;
    logic [31:0] ALU_REG_OUT = '0;
    logic [31:0] Reg1_Out = '0;
    logic        MEM_READY = 1'b0;
    logic [31:0] MEM_RDATA = '0;
    logic        MEM_REQ;
    logic [31:0] MEM_ADDR;
    logic [31:0] Instr;
    logic        IR_VALID;
    logic [31:0] PC_OUT;
    logic [31:0] EPC_OUT;
    logic        FETCH_BUSY;
    logic        FETCH_ERR;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;

    instr_fetch_hs_unit dut (
        .CLK(CLK), .RST(RST), .FETCH_REQ(FETCH_REQ), .PC_LOAD(PC_LOAD),
        .PC_SEL(PC_SEL), .EXC(EXC), .ALU_OUT(ALU_OUT), .ALU_REG_OUT(ALU_REG_OUT),
        .Reg1_Out(Reg1_Out), .MEM_READY(MEM_READY), .MEM_RDATA(MEM_RDATA),
        .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .Instr(Instr), .IR_VALID(IR_VALID),
        .PC_OUT(PC_OUT), .EPC_OUT(EPC_OUT), .FETCH_BUSY(FETCH_BUSY), .FETCH_ERR(FETCH_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        logic [31:0] e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s: observed=%h expected=<empty scoreboard>", tag, Instr);
        end else begin
            e = sb_q.pop_front();
            exp_instr = e;
            check(tag, Instr, e);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic load_pc(input logic [31:0] v);
        ALU_OUT = v; PC_SEL = 3'd0; PC_LOAD = 1'b1;
        tick();
        PC_LOAD = 1'b0;
        exp_pc = v;
    endtask

    function automatic logic [31:0] pc_model(input logic [2:0] sel, input logic [31:0] pc,
                                             input logic [31:0] ir);
        case (sel)
            3'd0: return ALU_OUT;
            3'd1: return ALU_REG_OUT;
            3'd2: return {pc[31:28], ir[25:0], 2'b00};
            3'd3: return Reg1_Out;
            3'd4: return 32'h0000_0000;
            3'd5: return 32'h0000_0180;
            default: return pc;
        endcase
    endfunction

    // Fetch from current PC; ready asserted on REQ cycle n_wait+1.
    task automatic fetch(input int n_wait, input logic [31:0] data, input string tag);
        logic [31:0] addr;
        addr = exp_pc;
        FETCH_REQ = 1'b1;
        tick();
        FETCH_REQ = 1'b0;
        for (int i = 0; i <= n_wait; i++) begin
            check({tag, "_req"}, {31'd0, MEM_REQ}, 32'd1);
            check({tag, "_addr"}, MEM_ADDR, addr);
            if (i == n_wait) begin
                MEM_READY = 1'b1;
                MEM_RDATA = data;
                sb_q.push_back(data);
            end
            tick();
        end
        MEM_READY = 1'b0;
        check({tag, "_valid"}, {31'd0, IR_VALID}, 32'd1);
        check({tag, "_busy"}, {31'd0, FETCH_BUSY}, 32'd0);
        check({tag, "_req_off"}, {31'd0, MEM_REQ}, 32'd0);
        sb_check({tag, "_instr"});
    endtask

    initial begin
        logic [2:0] sels [7];
        sels = '{3'd0, 3'd2, 3'd1, 3'd3, 3'd6, 3'd4, 3'd5};
        exp_pc = 32'h0;
        exp_instr = 32'h0;

        // Reset state
        tick(); tick();
        check("rst_pc", PC_OUT, 32'h0);
        check("rst_instr", Instr, 32'h0);
        check("rst_epc", EPC_OUT, 32'h0);
        check("rst_addr", MEM_ADDR, 32'h0);
        check("rst_flags", {28'd0, MEM_REQ, IR_VALID, FETCH_BUSY, FETCH_ERR}, 32'h0);
        RST = 1'b0;
        tick();

        // Basic fetch, ready after 3 wait cycles
        fetch(3, 32'h0800_0010, "f1");

        // Next-PC mux
        ALU_OUT = 32'h1111_0000; ALU_REG_OUT = 32'h2222_0004; Reg1_Out = 32'h3333_0008;
        PC_LOAD = 1'b1;
        foreach (sels[k]) begin
            PC_SEL = sels[k];
            exp_pc = pc_model(sels[k], exp_pc, exp_instr);
            tick();
            check($sformatf("pcsel%0d", sels[k]), PC_OUT, exp_pc);
            if (sels[k] == 3'd5) ALU_OUT = 32'h7777_0000;
        end
        PC_LOAD = 1'b0;
        load_pc(32'hA000_0000);
        PC_SEL = 3'd2; PC_LOAD = 1'b1;
        tick();
        PC_LOAD = 1'b0;
        check("jump", PC_OUT, 32'hA000_0040);
        exp_pc = 32'hA000_0040;

        // Timeout: never ready
        load_pc(32'h0000_0100);
        FETCH_REQ = 1'b1;
        tick();
        FETCH_REQ = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            check($sformatf("to_req%0d", i), {30'd0, MEM_REQ, FETCH_ERR}, 32'h2);
            tick();
        end
        check("to_err", {30'd0, FETCH_ERR, MEM_REQ}, 32'h2);
        check("to_valid", {31'd0, IR_VALID}, 32'd0);
        check("to_instr", Instr, exp_instr);
        tick();
        check("to_idle", {30'd0, FETCH_ERR, FETCH_BUSY}, 32'h0);

        // Ready on 15th cycle beats timeout
        fetch(14, 32'h1234_5678, "to15");
        check("to15_noerr", {31'd0, FETCH_ERR}, 32'd0);

        // Misaligned PC
        load_pc(32'h0000_0006);
        FETCH_REQ = 1'b1;
        tick();
        FETCH_REQ = 1'b0;
        check("mis_noreq", {31'd0, MEM_REQ}, 32'd0);
        check("mis_err", {31'd0, FETCH_ERR}, 32'd1);
        tick();
        check("mis_done", {30'd0, FETCH_ERR, FETCH_BUSY}, 32'h0);

        // PC_LOAD and FETCH_REQ together: fetch uses old PC
        load_pc(32'h0000_0200);
        ALU_OUT = 32'h0000_0300; PC_LOAD = 1'b1; FETCH_REQ = 1'b1;
        tick();
        PC_LOAD = 1'b0; FETCH_REQ = 1'b0;
        check("pl_addr", MEM_ADDR, 32'h0000_0200);
        check("pl_pc", PC_OUT, 32'h0000_0300);
        MEM_READY = 1'b1; MEM_RDATA = 32'h0BAD_F00D; sb_q.push_back(32'h0BAD_F00D);
        tick();
        MEM_READY = 1'b0;
        sb_check("pl_instr");

        // Exception during REQ cycle 2
        load_pc(32'h0000_0040);
        FETCH_REQ = 1'b1;
        tick();
        FETCH_REQ = 1'b0;
        check("exc_req1", {31'd0, MEM_REQ}, 32'd1);
        tick();
        EXC = 1'b1;
        tick();
        EXC = 1'b0;
        check("exc_epc", EPC_OUT, 32'h0000_0040);
        check("exc_pc", PC_OUT, 32'h0000_0180);
        check("exc_drain", {29'd0, MEM_REQ, FETCH_BUSY, IR_VALID}, 32'h6);
        check("exc_addr", MEM_ADDR, 32'h0000_0040);
        tick();
        check("exc_hold", {31'd0, MEM_REQ}, 32'd1);
        MEM_READY = 1'b1; MEM_RDATA = 32'hDEAD_BEEF;
        tick();
        MEM_READY = 1'b0;
        check("exc_end", {29'd0, MEM_REQ, FETCH_BUSY, IR_VALID}, 32'h0);
        check("exc_drop", Instr, exp_instr);
        exp_pc = 32'h0000_0180;
        fetch(0, 32'hCAFE_0001, "exc_next");

        // Async reset mid-REQ
        load_pc(32'h0000_0400);
        FETCH_REQ = 1'b1;
        tick();
        FETCH_REQ = 1'b0;
        check("ar_req", {31'd0, MEM_REQ}, 32'd1);
        #2 RST = 1'b1;
        #1;
        check("ar_req_drop", {31'd0, MEM_REQ}, 32'd0);
        check("ar_pc", PC_OUT, 32'h0);
        check("ar_instr", Instr, 32'h0);
        check("ar_regs", EPC_OUT | MEM_ADDR, 32'h0);
        check("ar_flags", {29'd0, IR_VALID, FETCH_BUSY, FETCH_ERR}, 32'h0);
        tick();
        RST = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
